// File: rtl/i2si_rx_fifo_if.sv
// rtl/i2si_rx_fifo_if.sv - read-side pop and status bundle of the I2S receive FIFO
interface i2si_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 3
);
  logic                  fifo_rd_req;
  logic [31:0]           fifo_rd_data;
  logic                  fifo_rd_valid;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [DEPTH_LOG2:0]   fifo_level;
  logic                  fifo_afull;
  logic                  fifo_ovr;
  logic [7:0]            chk_err_cnt;

  // register-file side: issues pops, observes data and status
  modport master (
    output fifo_rd_req,
    input  fifo_rd_data, fifo_rd_valid, fifo_empty, fifo_full,
           fifo_level, fifo_afull, fifo_ovr, chk_err_cnt
  );

  // FIFO side
  modport slave (
    input  fifo_rd_req,
    output fifo_rd_data, fifo_rd_valid, fifo_empty, fifo_full,
           fifo_level, fifo_afull, fifo_ovr, chk_err_cnt
  );
endinterface

// File: rtl/i2si_rx_fifo.sv
// rtl/i2si_rx_fifo.sv - I2S receive word FIFO, source select, overrun flag, optional BIST check (I2SI_RX_FIFO_CHK_EN)
module i2si_rx_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int AF_THRESH  = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rf_bist_en,
  input  logic [31:0] i2si_bist_out_data,
  input  logic        i2si_bist_out_xfc,
  input  logic [31:0] i2si_sd_data,
  input  logic        i2si_sd_xfc,
  input  logic        rf_fifo_clr,
  input  logic        rf_ovr_clr,
  i2si_rx_fifo_if.slave rd
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_AF   = (DEPTH_LOG2+1)'(AF_THRESH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [31:0]           rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  ovr_q, ovr_d;

  logic        wr_en, wr_ok, wr_drop, rd_ok, is_full, is_empty;
  logic [31:0] wr_data;

  // source select and accept/drop decisions; a flush discards both sides
  always_comb begin
    wr_en    = rf_bist_en ? i2si_bist_out_xfc  : i2si_sd_xfc;
    wr_data  = rf_bist_en ? i2si_bist_out_data : i2si_sd_data;
    is_full  = (level_q == LVL_FULL);
    is_empty = (level_q == '0);
    rd_ok    = rd.fifo_rd_req && !is_empty && !rf_fifo_clr;
    wr_ok    = wr_en && !rf_fifo_clr && (!is_full || rd_ok);
    wr_drop  = wr_en && !rf_fifo_clr && is_full && !rd_ok;
  end

  // pointer, level, pop data and overrun next-state
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovr_d      = ovr_q;
    if (rf_fifo_clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + PTR_ONE;
      if (rd_ok) begin
        rptr_d     = rptr_q + PTR_ONE;
        rd_data_d  = mem_q[rptr_q];
        rd_valid_d = 1'b1;
      end
      if (wr_ok && !rd_ok)      level_d = level_q + LVL_ONE;
      else if (rd_ok && !wr_ok) level_d = level_q - LVL_ONE;
    end
    if (wr_drop)         ovr_d = 1'b1;
    else if (rf_ovr_clr) ovr_d = 1'b0;
  end

  // control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovr_q      <= ovr_d;
    end
  end

  // word storage; contents are don't-care after reset since level is zero
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= wr_data;
  end

  assign rd.fifo_rd_data  = rd_data_q;
  assign rd.fifo_rd_valid = rd_valid_q;
  assign rd.fifo_level    = level_q;
  assign rd.fifo_empty    = is_empty;
  assign rd.fifo_full     = is_full;
  assign rd.fifo_afull    = (level_q >= LVL_AF);
  assign rd.fifo_ovr      = ovr_q;

`ifdef I2SI_RX_FIFO_CHK_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       fmt_bad;

  // BIST words carry their low half inverted in the high half; count accepted words that do not
  always_comb begin
    fmt_bad   = wr_ok && rf_bist_en && (wr_data[31:16] != ~wr_data[15:0]);
    err_cnt_d = err_cnt_q;
    if (fmt_bad) begin
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end else if (rf_ovr_clr) begin
      err_cnt_d = 8'd0;
    end
  end

  // error counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign rd.chk_err_cnt = err_cnt_q;
`else
  assign rd.chk_err_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_i2si_rx_fifo.sv
// tb/tb_i2si_rx_fifo.sv - self-checking bench for i2si_rx_fifo with a queue-based reference model
module tb_i2si_rx_fifo;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rf_bist_en = 1'b0;
  logic [31:0] i2si_bist_out_data = '0;
  logic        i2si_bist_out_xfc = 1'b0;
  logic [31:0] i2si_sd_data = '0;
  logic        i2si_sd_xfc = 1'b0;
  logic        rf_fifo_clr = 1'b0;
  logic        rf_ovr_clr = 1'b0;

  i2si_rx_fifo_if #(.DEPTH_LOG2(3)) rd_if ();

  i2si_rx_fifo #(.DEPTH_LOG2(3), .AF_THRESH(6)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rf_bist_en         (rf_bist_en),
    .i2si_bist_out_data (i2si_bist_out_data),
    .i2si_bist_out_xfc  (i2si_bist_out_xfc),
    .i2si_sd_data       (i2si_sd_data),
    .i2si_sd_xfc        (i2si_sd_xfc),
    .rf_fifo_clr        (rf_fifo_clr),
    .rf_ovr_clr         (rf_ovr_clr),
    .rd                 (rd_if.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a word queue of capacity 8
  logic [31:0] q[$];
  logic [31:0] m_data = '0;
  logic        m_valid = 1'b0;
  logic        m_ovr = 1'b0;
  int          m_err = 0;
  bit          chk_build;

  initial begin
`ifdef I2SI_RX_FIFO_CHK_EN
    chk_build = 1'b1;
`else
    chk_build = 1'b0;
`endif
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_err = 0;
    end else begin
      logic        w;
      logic [31:0] wd;
      bit          took, dropped, popped;
      int          sz;
      w  = rf_bist_en ? i2si_bist_out_xfc : i2si_sd_xfc;
      wd = rf_bist_en ? i2si_bist_out_data : i2si_sd_data;
      sz = q.size();
      took = 0; dropped = 0; popped = 0;
      m_valid = 1'b0;
      if (rf_fifo_clr) begin
        q.delete();
      end else begin
        if (rd_if.fifo_rd_req && sz > 0) begin
          m_data = q.pop_front();
          m_valid = 1'b1;
          popped = 1;
        end
        if (w) begin
          if (sz < 8 || popped) begin q.push_back(wd); took = 1; end
          else dropped = 1;
        end
      end
      if (dropped) m_ovr = 1'b1;
      else if (rf_ovr_clr) m_ovr = 1'b0;
      if (chk_build && took && rf_bist_en && (wd[31:16] != ~wd[15:0])) begin
        if (m_err < 255) m_err = m_err + 1;
      end else if (chk_build && rf_ovr_clr) begin
        m_err = 0;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("level", 32'(rd_if.fifo_level), 32'(q.size()));
    chk("empty", 32'(rd_if.fifo_empty), 32'(q.size() == 0));
    chk("full",  32'(rd_if.fifo_full),  32'(q.size() == 8));
    chk("afull", 32'(rd_if.fifo_afull), 32'(q.size() >= 6));
    chk("ovr",   32'(rd_if.fifo_ovr),   32'(m_ovr));
    chk("rd_valid", 32'(rd_if.fifo_rd_valid), 32'(m_valid));
    chk("rd_data", rd_if.fifo_rd_data, m_data);
    chk("err_cnt", 32'(rd_if.chk_err_cnt), 32'(m_err));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr_bist(input logic [31:0] d);
    rf_bist_en = 1'b1; i2si_bist_out_data = d; i2si_bist_out_xfc = 1'b1;
    tick();
    i2si_bist_out_xfc = 1'b0;
  endtask

  task automatic wr_sd(input logic [31:0] d);
    rf_bist_en = 1'b0; i2si_sd_data = d; i2si_sd_xfc = 1'b1;
    tick();
    i2si_sd_xfc = 1'b0;
  endtask

  task automatic rd_word(input string name, input logic [31:0] exp);
    rd_if.fifo_rd_req = 1'b1;
    tick();
    rd_if.fifo_rd_req = 1'b0;
    chk({name, "_valid"}, 32'(rd_if.fifo_rd_valid), 32'd1);
    chk(name, rd_if.fifo_rd_data, exp);
    tick();
    chk({name, "_single"}, 32'(rd_if.fifo_rd_valid), 32'd0);
  endtask

  task automatic pulse_ovr_clr();
    rf_ovr_clr = 1'b1; tick(); rf_ovr_clr = 1'b0;
  endtask

  task automatic pulse_fifo_clr();
    rf_fifo_clr = 1'b1; tick(); rf_fifo_clr = 1'b0;
  endtask

  initial begin
    rd_if.fifo_rd_req = 1'b0;
    repeat (3) tick();
    chk("rst_empty", 32'(rd_if.fifo_empty), 32'd1);
    chk("rst_level", 32'(rd_if.fifo_level), 32'd0);
    chk("rst_data",  rd_if.fifo_rd_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // BIST words with wide spacing, then drain in order
    wr_bist(32'hFFFF0000); repeat (31) tick();
    wr_bist(32'hFFFE0001); repeat (31) tick();
    wr_bist(32'hFFFD0002); repeat (31) tick();
    chk("bist_level3", 32'(rd_if.fifo_level), 32'd3);
    rd_word("bist_rd0", 32'hFFFF0000);
    rd_word("bist_rd1", 32'hFFFE0001);
    rd_word("bist_rd2", 32'hFFFD0002);
    chk("bist_level0", 32'(rd_if.fifo_level), 32'd0);

    // deselected source ignored
    rf_bist_en = 1'b1; i2si_sd_data = 32'hDEAD0000; i2si_sd_xfc = 1'b1;
    tick(); i2si_sd_xfc = 1'b0;
    chk("desel_ignored", 32'(rd_if.fifo_level), 32'd0);

    // fill with deserializer words, ninth overruns
    for (int i = 0; i < 9; i++) begin
      wr_sd(32'h100 + i);
      if (i == 4) chk("afull_at5", 32'(rd_if.fifo_afull), 32'd0);
      if (i == 5) chk("afull_at6", 32'(rd_if.fifo_afull), 32'd1);
    end
    chk("fill_level", 32'(rd_if.fifo_level), 32'd8);
    chk("fill_full",  32'(rd_if.fifo_full), 32'd1);
    chk("fill_ovr",   32'(rd_if.fifo_ovr), 32'd1);
    pulse_ovr_clr();
    chk("ovr_cleared", 32'(rd_if.fifo_ovr), 32'd0);
    // drop coincident with clear: set wins
    rf_ovr_clr = 1'b1; wr_sd(32'h1FF); rf_ovr_clr = 1'b0;
    chk("ovr_set_wins", 32'(rd_if.fifo_ovr), 32'd1);
    rd_word("fill_rd_first", 32'h100);
    pulse_ovr_clr();
    chk("ovr_cleared2", 32'(rd_if.fifo_ovr), 32'd0);
    wr_sd(32'h200);
    chk("refull", 32'(rd_if.fifo_full), 32'd1);

    // simultaneous write and read at full
    rf_bist_en = 1'b0; i2si_sd_data = 32'h201; i2si_sd_xfc = 1'b1; rd_if.fifo_rd_req = 1'b1;
    tick();
    i2si_sd_xfc = 1'b0; rd_if.fifo_rd_req = 1'b0;
    chk("full_rw_data",  rd_if.fifo_rd_data, 32'h101);
    chk("full_rw_level", 32'(rd_if.fifo_level), 32'd8);
    chk("full_rw_ovr",   32'(rd_if.fifo_ovr), 32'd0);
    pulse_fifo_clr();
    chk("clr_empty", 32'(rd_if.fifo_empty), 32'd1);

    // simultaneous write and read at empty: no fall-through
    i2si_sd_data = 32'h300; i2si_sd_xfc = 1'b1; rd_if.fifo_rd_req = 1'b1;
    tick();
    i2si_sd_xfc = 1'b0; rd_if.fifo_rd_req = 1'b0;
    chk("empty_rw_valid", 32'(rd_if.fifo_rd_valid), 32'd0);
    chk("empty_rw_level", 32'(rd_if.fifo_level), 32'd1);
    rd_word("empty_rw_rd", 32'h300);

    // five words, then flush coincident with a write
    for (int i = 0; i < 5; i++) wr_sd(32'h500 + i);
    rd_word("pre_clr_rd", 32'h500);
    wr_sd(32'h505);
    rf_fifo_clr = 1'b1; i2si_sd_data = 32'h999; i2si_sd_xfc = 1'b1;
    tick();
    rf_fifo_clr = 1'b0; i2si_sd_xfc = 1'b0;
    chk("flush_level", 32'(rd_if.fifo_level), 32'd0);
    chk("flush_empty", 32'(rd_if.fifo_empty), 32'd1);
    chk("flush_keeps_data", rd_if.fifo_rd_data, 32'h500);
    wr_sd(32'h400);
    rd_word("post_clr_rd", 32'h400);

    // BIST format check
    wr_bist(32'h12340000);
    tick();
    chk("chk_bad", 32'(rd_if.chk_err_cnt), chk_build ? 32'd1 : 32'd0);
    wr_bist(32'hEDCB1234);
    tick();
    chk("chk_good", 32'(rd_if.chk_err_cnt), chk_build ? 32'd1 : 32'd0);
    pulse_ovr_clr();
    chk("chk_cleared", 32'(rd_if.chk_err_cnt), 32'd0);

    // asynchronous reset mid-operation
    wr_sd(32'h600);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_level", 32'(rd_if.fifo_level), 32'd0);
    chk("async_rst_data",  rd_if.fifo_rd_data, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/i2si_rx_fifo.md
# i2si_rx_fifo

Receive-side word buffer for the I2S input path. Selects one of two 32-bit word sources, the serial deserializer or the BIST sawtooth generator, and writes the selected word into a synchronous FIFO on that source's transfer-complete pulse. The register interface drains the FIFO one word per read request. The block reports level, full/empty, almost-full and a sticky overrun flag, and optionally checks the BIST word-integrity format.

## Interface
- DEPTH_LOG2, 3: FIFO depth = 2^DEPTH_LOG2 words (8)
- AF_THRESH, 6: almost-full threshold in words, range 1..2^DEPTH_LOG2
- clk  in  1  master clock
- rst_n  in  1  reset, asynchronous, active-low
- rf_bist_en  in  1  source select: 1 = BIST, 0 = deserializer
- i2si_bist_out_data  in  32  BIST word
- i2si_bist_out_xfc  in  1  BIST word-valid pulse, one clk
- i2si_sd_data  in  32  deserializer word
- i2si_sd_xfc  in  1  deserializer word-valid pulse, one clk
- rf_fifo_clr  in  1  flush pulse
- rf_ovr_clr  in  1  clears overrun flag
- fifo_rd_req  in  1  pop request pulse
- fifo_rd_data  out  32  popped word, held until the next pop
- fifo_rd_valid  out  1  one-clk pulse when fifo_rd_data updates
- fifo_empty  out  1  level == 0
- fifo_full  out  1  level == 2^DEPTH_LOG2
- fifo_level  out  DEPTH_LOG2+1  stored word count
- fifo_afull  out  1  level >= AF_THRESH
- fifo_ovr  out  1  sticky overrun
- chk_err_cnt  out  8  BIST format error count

## Operation
- Write strobe: wr = rf_bist_en ? i2si_bist_out_xfc : i2si_sd_xfc. Write data comes from the same source. rf_bist_en is sampled in the same cycle as the xfc. An xfc from the deselected source is ignored.
- Storage: 2^DEPTH_LOG2 x 32 register array. Write and read pointers are DEPTH_LOG2 bits wide and wrap modulo the depth. The level is a separate counter.
- Write when not full: store the word, advance wptr, level +1.
- Write when full with no read in the same cycle: the word is dropped, pointers are unchanged, and fifo_ovr is set.
- Read: fifo_rd_req with level > 0 pops the word at rptr into fifo_rd_data, pulses fifo_rd_valid, advances rptr, and decrements level by 1.
- Read when empty is ignored: no valid pulse and fifo_rd_data holds. A write arriving in the same cycle as a read at empty does not fall through; the read is still ignored and the write is stored.
- Write and read in the same cycle with level > 0, including full: both are performed, level is unchanged, and no overrun occurs.
- rf_fifo_clr: wptr, rptr and level go to 0. It takes priority over any same-cycle write or read, and both are discarded. It does not clear fifo_ovr, fifo_rd_data or chk_err_cnt.
- fifo_ovr: set has priority over a same-cycle rf_ovr_clr. Otherwise rf_ovr_clr clears it.
- fifo_empty, fifo_full and fifo_afull are decoded combinationally from the registered level.

## Timing
- Reset values: fifo_rd_data 0, fifo_rd_valid 0, fifo_level 0, fifo_empty 1, fifo_full 0, fifo_afull 0, fifo_ovr 0, chk_err_cnt 0, and both pointers 0.
- Write latency: the level and flags reflect a write on the clk edge following the xfc cycle.
- Read latency: fifo_rd_data and fifo_rd_valid are registered and appear one clk after the fifo_rd_req cycle.
- fifo_ovr asserts one clk after the dropped write.
- Reset asserted mid-operation: all state returns to reset values immediately. Stored contents are considered lost.

## Configuration
- I2SI_RX_FIFO_CHK_EN defined: for every accepted write with rf_bist_en = 1, the block checks data[31:16] == ~data[15:0].
  - On a mismatch, chk_err_cnt increments one clk later and saturates at 255.
  - chk_err_cnt is cleared by rf_ovr_clr.
  - Dropped writes are not checked.
- I2SI_RX_FIFO_CHK_EN undefined: no check logic is built and chk_err_cnt is tied to 0. The port is present in both builds.

## Test plan
- Reset, then BIST words 0xFFFF0000, 0xFFFE0001, 0xFFFD0002 with 32-clk spacing, then three reads: data returns in order, each with a single fifo_rd_valid one clk after its request, and level goes 3->0.
- rf_bist_en = 0 and 9 sd writes with no reads: level 8, fifo_full = 1 and fifo_afull = 1 (asserted from level 6). The 9th word is dropped and fifo_ovr = 1. The next read returns the 1st word. rf_ovr_clr then clears fifo_ovr.
- FIFO full, then a same-cycle sd_xfc and fifo_rd_req: the oldest word is returned, the new word is stored, level stays 8, and fifo_ovr stays 0.
- Empty, then a same-cycle xfc and rd_req: no fifo_rd_valid, level becomes 1, and a read one cycle later returns the word.
- 5 words stored, then rf_fifo_clr in the same cycle as an xfc: level 0, fifo_empty = 1, and the next write lands and reads back correctly despite the pointer reset.
- CHK_EN build, rf_bist_en = 1: writing 0x12340000 gives chk_err_cnt = 1, and writing 0xEDCB1234 leaves it at 1. In the build without the macro, chk_err_cnt stays 0.
